// File: rtl/note_player_if.sv
// Note/duration handshake from the song reader, frequency ROM port and
// phase/sample outputs toward the sine path, bundled for note_player.
interface note_player_if #(
    parameter int PHASE_W = 22,
    parameter int STEP_W  = 20
);
    logic               play;
    logic [5:0]         note;
    logic [5:0]         duration;
    logic               new_note;
    logic               beat;
    logic               generate_next_sample;
    logic [STEP_W-1:0]  freq_step;
    logic [5:0]         freq_addr;
    logic               note_done;
    logic [PHASE_W-1:0] phase;
    logic               sample_valid;
    logic               rest;
    logic               busy;

    modport master (
        output play, note, duration, new_note, beat, generate_next_sample, freq_step,
        input  freq_addr, note_done, phase, sample_valid, rest, busy
    );

    modport slave (
        input  play, note, duration, new_note, beat, generate_next_sample, freq_step,
        output freq_addr, note_done, phase, sample_valid, rest, busy
    );
endinterface

// File: rtl/note_player.sv
// Latches one note at a time, counts its beats and steps a phase accumulator
// per sample request; pulses note_done when the beats run out.
module note_player #(
    parameter int LOAD_DELAY = 2,
    parameter int PHASE_W    = 22,
    parameter int STEP_W     = 20
) (
    input logic          clk,
    input logic          reset,
    note_player_if.slave bus
);
    localparam int DLY_W = (LOAD_DELAY > 1) ? $clog2(LOAD_DELAY) : 1;
    localparam logic [DLY_W-1:0] DLY_INIT = DLY_W'(LOAD_DELAY - 1);

    typedef enum logic [2:0] {IDLE, ARM, FETCH, PLAYING, DONE_WAIT} state_t;

    state_t             state;
    logic [DLY_W-1:0]   dly;
    logic [5:0]         note_q;
    logic [5:0]         dur_q;
    logic [5:0]         beat_cnt;
    logic [PHASE_W-1:0] phase_q;
    logic               note_done_q;
    logic               sample_valid_q;
    logic               rest_q;
    logic               busy_q;
    logic               last_beat;

    // 7-bit compare so a beat count of 63 never aliases onto duration 0
    assign last_beat = ({1'b0, beat_cnt} + 7'd1) == {1'b0, dur_q};

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            dly            <= '0;
            note_q         <= '0;
            dur_q          <= '0;
            beat_cnt       <= '0;
            phase_q        <= '0;
            note_done_q    <= 1'b0;
            sample_valid_q <= 1'b0;
            rest_q         <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            note_done_q    <= 1'b0;
            sample_valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    // the first note of a song shows up without a new_note pulse
                    if (bus.new_note || (bus.play && bus.duration != 6'd0)) begin
                        dly    <= DLY_INIT;
                        busy_q <= 1'b1;
                        state  <= ARM;
                    end
                end
                ARM: begin
                    if (bus.new_note) begin
                        dly <= DLY_INIT;
                    end else if (dly == '0) begin
                        note_q   <= bus.note;
                        dur_q    <= bus.duration;
                        rest_q   <= (bus.note == 6'd0);
                        beat_cnt <= '0;
                        phase_q  <= '0;
                        state    <= FETCH;
                    end else begin
                        dly <= dly - 1'b1;
                    end
                end
                FETCH: begin
                    if (bus.new_note) begin
                        dly   <= DLY_INIT;
                        state <= ARM;
                    end else begin
                        state <= PLAYING;
                    end
                end
                PLAYING: begin
                    if (bus.new_note) begin
                        dly   <= DLY_INIT;
                        state <= ARM;
                    end else if (dur_q == 6'd0) begin
                        note_done_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state       <= DONE_WAIT;
                    end else if (bus.play) begin
                        if (bus.generate_next_sample) begin
                            phase_q        <= rest_q ? '0 : phase_q + PHASE_W'(bus.freq_step);
                            sample_valid_q <= 1'b1;
                        end
                        if (bus.beat) begin
                            if (last_beat) begin
                                note_done_q <= 1'b1;
                                busy_q      <= 1'b0;
                                state       <= DONE_WAIT;
                            end else begin
                                beat_cnt <= beat_cnt + 1'b1;
                            end
                        end
                    end
                end
                DONE_WAIT: begin
                    if (bus.new_note) begin
                        dly    <= DLY_INIT;
                        busy_q <= 1'b1;
                        state  <= ARM;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.freq_addr    = note_q;
    assign bus.note_done    = note_done_q;
    assign bus.phase        = phase_q;
    assign bus.sample_valid = sample_valid_q;
    assign bus.rest         = rest_q;
    assign bus.busy         = busy_q;
endmodule

// File: tb/tb_note_player.sv
// Scoreboard bench for note_player: expected phases queued per sample request,
// compared against phases captured whenever sample_valid fires.
module tb_note_player;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    note_player_if #(.PHASE_W(22), .STEP_W(20)) bus ();
    note_player #(.LOAD_DELAY(2), .PHASE_W(22), .STEP_W(20)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int vectors = 0;
    int miscompares = 0;
    logic [21:0] exp_q[$];
    logic [21:0] obs_ph [256];
    int obs_wr = 0;
    int obs_rd = 0;
    int nd_cnt = 0;
    logic [5:0]  note_m;
    logic [21:0] mphase;
    logic        rest_m;

    function automatic logic [19:0] rom_f(input logic [5:0] n);
        if (n == 6'd63) return 20'hFFFFF;
        return {n, 14'h0155};
    endfunction

    // frequency ROM: one-cycle read latency
    always @(posedge clk) bus.freq_step <= rom_f(bus.freq_addr);

    always @(negedge clk) begin
        if (bus.sample_valid) begin
            obs_ph[obs_wr % 256] <= bus.phase;
            obs_wr <= obs_wr + 1;
        end
        if (bus.note_done) nd_cnt <= nd_cnt + 1;
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_beat();
        bus.beat = 1'b1;
        cyc();
        bus.beat = 1'b0;
    endtask

    task automatic pulse_gen();
        bus.generate_next_sample = 1'b1;
        mphase = rest_m ? 22'd0 : mphase + 22'(rom_f(note_m));
        exp_q.push_back(mphase);
        cyc();
        bus.generate_next_sample = 1'b0;
    endtask

    // new_note pulse, then ARM (LOAD_DELAY) + FETCH; returns in PLAYING
    task automatic start_note(input logic [5:0] n, input logic [5:0] d);
        bus.note = n;
        bus.duration = d;
        bus.new_note = 1'b1;
        cyc();
        bus.new_note = 1'b0;
        cyc(3);
        note_m = n;
        mphase = 22'd0;
        rest_m = (n == 6'd0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.play = 1'b0;
        bus.note = 6'd0;
        bus.duration = 6'd0;
        bus.new_note = 1'b0;
        bus.beat = 1'b0;
        bus.generate_next_sample = 1'b0;
        cyc(2);
        reset = 1'b0;
        cyc();
        vectors++; if (bus.phase !== 22'd0) begin miscompares++; $display("FAIL reset_phase got=%h want=0", bus.phase); end
        vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
        vectors++; if (bus.note_done !== 1'b0) begin miscompares++; $display("FAIL reset_note_done got=%b want=0", bus.note_done); end
        vectors++; if (bus.sample_valid !== 1'b0) begin miscompares++; $display("FAIL reset_sample_valid got=%b want=0", bus.sample_valid); end
        vectors++; if (bus.rest !== 1'b0) begin miscompares++; $display("FAIL reset_rest got=%b want=0", bus.rest); end
        vectors++; if (bus.freq_addr !== 6'd0) begin miscompares++; $display("FAIL reset_freq_addr got=%0d want=0", bus.freq_addr); end
    endtask

    task automatic test_basic();
        int nd0;
        int ow;
        logic [21:0] e;
        nd0 = nd_cnt;
        bus.note = 6'd12;
        bus.duration = 6'd3;
        bus.play = 1'b1;
        cyc();
        vectors++; if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL basic_arm_busy got=%b want=1", bus.busy); end
        cyc();
        vectors++; if (bus.freq_addr !== 6'd0) begin miscompares++; $display("FAIL basic_early_latch got=%0d want=0", bus.freq_addr); end
        cyc();
        vectors++; if (bus.freq_addr !== 6'd12) begin miscompares++; $display("FAIL basic_latch got=%0d want=12", bus.freq_addr); end
        cyc();
        note_m = 6'd12; mphase = 22'd0; rest_m = 1'b0;
        bus.note = 6'd30;
        bus.duration = 6'd9;
        pulse_gen();
        pulse_gen();
        cyc();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            if (obs_rd == obs_wr) begin miscompares++; $display("FAIL basic_sample missing want=%h", e); end
            else begin
                if (obs_ph[obs_rd % 256] !== e) begin miscompares++; $display("FAIL basic_sample got=%h want=%h", obs_ph[obs_rd % 256], e); end
                obs_rd++;
            end
        end
        vectors++; if (bus.freq_addr !== 6'd12) begin miscompares++; $display("FAIL basic_note_hold got=%0d want=12", bus.freq_addr); end
        pulse_beat();
        pulse_beat();
        vectors++; if (bus.note_done !== 1'b0) begin miscompares++; $display("FAIL basic_early_done got=%b want=0", bus.note_done); end
        pulse_beat();
        vectors++; if (bus.note_done !== 1'b1 || bus.busy !== 1'b0) begin miscompares++; $display("FAIL basic_done got=%b/%b want=1/0", bus.note_done, bus.busy); end
        cyc();
        vectors++; if (bus.note_done !== 1'b0) begin miscompares++; $display("FAIL basic_done_width got=%b want=0", bus.note_done); end
        // beats and requests in DONE_WAIT do nothing
        ow = obs_wr;
        bus.beat = 1'b1;
        bus.generate_next_sample = 1'b1;
        cyc(3);
        bus.beat = 1'b0;
        bus.generate_next_sample = 1'b0;
        cyc();
        vectors++; if (obs_wr !== ow || nd_cnt - nd0 !== 1 || bus.busy !== 1'b0) begin
            miscompares++; $display("FAIL done_wait_ignore samples=%0d dones=%0d busy=%b want=0/1/0", obs_wr - ow, nd_cnt - nd0, bus.busy);
        end
    endtask

    task automatic test_phase_wrap();
        logic [21:0] e;
        bus.note = 6'd63;
        bus.duration = 6'd5;
        bus.new_note = 1'b1;
        cyc();
        bus.new_note = 1'b0;
        vectors++; if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL b2b_rearm got=%b want=1", bus.busy); end
        cyc(3);
        note_m = 6'd63; mphase = 22'd0; rest_m = 1'b0;
        for (int i = 0; i < 6; i++) begin
            pulse_gen();
            vectors++; if (bus.sample_valid !== 1'b1 || bus.phase !== mphase) begin
                miscompares++; $display("FAIL wrap_step%0d valid=%b phase=%h want=1/%h", i, bus.sample_valid, bus.phase, mphase);
            end
            if (i == 4) begin
                vectors++; if (bus.phase !== 22'h0FFFFB) begin miscompares++; $display("FAIL wrap_value got=%h want=0ffffb", bus.phase); end
            end
            cyc();
            vectors++; if (bus.sample_valid !== 1'b0) begin miscompares++; $display("FAIL wrap_valid_width%0d got=%b want=0", i, bus.sample_valid); end
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            if (obs_rd == obs_wr) begin miscompares++; $display("FAIL wrap_sample missing want=%h", e); end
            else begin
                if (obs_ph[obs_rd % 256] !== e) begin miscompares++; $display("FAIL wrap_sample got=%h want=%h", obs_ph[obs_rd % 256], e); end
                obs_rd++;
            end
        end
        repeat (5) pulse_beat();
        vectors++; if (bus.note_done !== 1'b1) begin miscompares++; $display("FAIL wrap_done got=%b want=1", bus.note_done); end
        cyc();
    endtask

    task automatic test_pause();
        int nd0;
        int ow;
        logic [21:0] e;
        start_note(6'd20, 6'd4);
        pulse_beat();
        pulse_gen();
        cyc();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            if (obs_rd == obs_wr) begin miscompares++; $display("FAIL pause_sample missing want=%h", e); end
            else begin
                if (obs_ph[obs_rd % 256] !== e) begin miscompares++; $display("FAIL pause_sample got=%h want=%h", obs_ph[obs_rd % 256], e); end
                obs_rd++;
            end
        end
        nd0 = nd_cnt;
        ow = obs_wr;
        bus.play = 1'b0;
        bus.beat = 1'b1;
        bus.generate_next_sample = 1'b1;
        cyc(10);
        bus.beat = 1'b0;
        bus.generate_next_sample = 1'b0;
        cyc();
        vectors++; if (bus.phase !== mphase) begin miscompares++; $display("FAIL pause_phase got=%h want=%h", bus.phase, mphase); end
        vectors++; if (obs_wr !== ow || nd_cnt !== nd0 || bus.busy !== 1'b1) begin
            miscompares++; $display("FAIL pause_frozen samples=%0d dones=%0d busy=%b want=0/0/1", obs_wr - ow, nd_cnt - nd0, bus.busy);
        end
        bus.play = 1'b1;
        pulse_beat();
        pulse_beat();
        vectors++; if (bus.note_done !== 1'b0) begin miscompares++; $display("FAIL pause_resume_early got=%b want=0", bus.note_done); end
        pulse_beat();
        vectors++; if (bus.note_done !== 1'b1) begin miscompares++; $display("FAIL pause_resume_done got=%b want=1", bus.note_done); end
        cyc();
    endtask

    task automatic test_rest_zero();
        logic [21:0] e;
        start_note(6'd0, 6'd2);
        vectors++; if (bus.rest !== 1'b1 || bus.freq_addr !== 6'd0) begin miscompares++; $display("FAIL rest_flag got=%b/%0d want=1/0", bus.rest, bus.freq_addr); end
        repeat (3) pulse_gen();
        cyc();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            if (obs_rd == obs_wr) begin miscompares++; $display("FAIL rest_sample missing want=%h", e); end
            else begin
                if (obs_ph[obs_rd % 256] !== e) begin miscompares++; $display("FAIL rest_sample got=%h want=%h", obs_ph[obs_rd % 256], e); end
                obs_rd++;
            end
        end
        pulse_beat();
        pulse_beat();
        vectors++; if (bus.note_done !== 1'b1) begin miscompares++; $display("FAIL rest_done got=%b want=1", bus.note_done); end
        cyc();
        start_note(6'd5, 6'd0);
        vectors++; if (bus.note_done !== 1'b0 || bus.busy !== 1'b1 || bus.rest !== 1'b0) begin
            miscompares++; $display("FAIL zero_entry done=%b busy=%b rest=%b want=0/1/0", bus.note_done, bus.busy, bus.rest);
        end
        cyc();
        vectors++; if (bus.note_done !== 1'b1 || bus.busy !== 1'b0) begin miscompares++; $display("FAIL zero_done got=%b/%b want=1/0", bus.note_done, bus.busy); end
        cyc();
        vectors++; if (bus.note_done !== 1'b0) begin miscompares++; $display("FAIL zero_done_width got=%b want=0", bus.note_done); end
    endtask

    task automatic test_abort();
        int nd0;
        logic [21:0] e;
        start_note(6'd7, 6'd3);
        pulse_beat();
        nd0 = nd_cnt;
        bus.note = 6'd9;
        bus.duration = 6'd2;
        bus.new_note = 1'b1;
        cyc();
        bus.new_note = 1'b0;
        vectors++; if (bus.busy !== 1'b1 || bus.note_done !== 1'b0) begin miscompares++; $display("FAIL abort_rearm busy=%b done=%b want=1/0", bus.busy, bus.note_done); end
        cyc();
        vectors++; if (bus.freq_addr !== 6'd7) begin miscompares++; $display("FAIL abort_early_latch got=%0d want=7", bus.freq_addr); end
        cyc();
        vectors++; if (bus.freq_addr !== 6'd9) begin miscompares++; $display("FAIL abort_latch got=%0d want=9", bus.freq_addr); end
        cyc();
        note_m = 6'd9; mphase = 22'd0; rest_m = 1'b0;
        pulse_gen();
        pulse_gen();
        cyc();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            if (obs_rd == obs_wr) begin miscompares++; $display("FAIL abort_sample missing want=%h", e); end
            else begin
                if (obs_ph[obs_rd % 256] !== e) begin miscompares++; $display("FAIL abort_sample got=%h want=%h", obs_ph[obs_rd % 256], e); end
                obs_rd++;
            end
        end
        vectors++; if (nd_cnt !== nd0) begin miscompares++; $display("FAIL abort_no_done got=%0d want=0", nd_cnt - nd0); end
        pulse_beat();
        vectors++; if (bus.note_done !== 1'b0) begin miscompares++; $display("FAIL abort_early_done got=%b want=0", bus.note_done); end
        pulse_beat();
        vectors++; if (bus.note_done !== 1'b1) begin miscompares++; $display("FAIL abort_done got=%b want=1", bus.note_done); end
        cyc();
        vectors++; if (nd_cnt - nd0 !== 1) begin miscompares++; $display("FAIL abort_done_count got=%0d want=1", nd_cnt - nd0); end
    endtask

    task automatic test_reset_mid();
        logic [21:0] e;
        start_note(6'd10, 6'd4);
        pulse_beat();
        pulse_beat();
        pulse_gen();
        cyc();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            if (obs_rd == obs_wr) begin miscompares++; $display("FAIL midrst_sample missing want=%h", e); end
            else begin
                if (obs_ph[obs_rd % 256] !== e) begin miscompares++; $display("FAIL midrst_sample got=%h want=%h", obs_ph[obs_rd % 256], e); end
                obs_rd++;
            end
        end
        reset = 1'b1;
        bus.play = 1'b0;
        cyc();
        reset = 1'b0;
        vectors++; if (bus.phase !== 22'd0 || bus.note_done !== 1'b0) begin miscompares++; $display("FAIL midrst_phase_done got=%h/%b want=0/0", bus.phase, bus.note_done); end
        vectors++; if (bus.busy !== 1'b0 || bus.freq_addr !== 6'd0) begin miscompares++; $display("FAIL midrst_busy_addr got=%b/%0d want=0/0", bus.busy, bus.freq_addr); end
        cyc(2);
        vectors++; if (bus.busy !== 1'b0 || obs_wr !== obs_rd) begin miscompares++; $display("FAIL midrst_idle busy=%b extra_samples=%0d want=0/0", bus.busy, obs_wr - obs_rd); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_phase_wrap();
        test_pause();
        test_rest_zero();
        test_abort();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
